// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and default word width.
package bit_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO; entry0 is always the head, so a pop moves entry1 forward.
module word_fifo2
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = entry0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        // do_push implies count < 2 and do_pop implies count > 0, so count is 1 here
        2'b11: entry0 <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: words queue in a 2-entry FIFO and are shifted out one bit per ser_en.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       fifo_count;
  logic [WIDTH-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             consume;
  logic             word_done;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign din_ready = (fifo_count != 2'd2);
  assign push      = din_valid && din_ready;
  assign consume   = ser_valid && ser_en;
  assign word_done = consume && (bit_cnt == LAST_BIT);
  // Reload either from IDLE or straight after the last bit, so back-to-back words have no gap
  assign pop       = (fifo_count != 2'd0) && ((state == IDLE) || word_done);
  assign busy      = (fifo_count != 2'd0) || (state == SHIFT);

  word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (din),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // ser_out is registered: shreg holds only the bits not yet presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (pop) begin
      state       <= SHIFT;
      shreg       <= drop_bit(fifo_head);
      bit_cnt     <= '0;
      ser_out     <= first_bit(fifo_head);
      ser_valid   <= 1'b1;
      frame_start <= 1'b1;
    end else if (word_done) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (consume) begin
      shreg       <= drop_bit(shreg);
      bit_cnt     <= bit_cnt + CNT_W'(1);
      ser_out     <= first_bit(shreg);
      frame_start <= 1'b0;
    end
  end

endmodule
